// File: rtl/exp2_fx.sv
// exp2_fx: bit-serial fixed-point base-2 antilog of a signed Q(M).N exponent.
// Optional macro EXP2_SAT_FLAG_EN adds oFlag = {underflow, saturated}.
module exp2_fx #(
  parameter int M = 4,
  parameter int N = 10,
  parameter int G = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iValid,
  output logic         iReady,
  input  logic [M+N:0] number,
  output logic         oValid,
  input  logic         oReady,
  output logic [M+N:0] expNumber
`ifdef EXP2_SAT_FLAG_EN
  ,
  output logic [1:0]   oFlag
`endif
);
  localparam int AW = 2 + N + G;
  localparam int KW = $clog2(N + 1);
  localparam int SW = AW + M;
  localparam int S  = 30;
  localparam logic signed [M:0] M_S = (M + 1)'(M);
  localparam logic [M+N:0] SAT_VAL = {1'b0, {(M + N){1'b1}}};

  typedef enum logic [1:0] {IDLE, ITER, SHIFT, DONE} state_t;

  function automatic logic [63:0] isqrt(input logic [63:0] v);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // 2^(2^-k): take k square roots of 2.0 at 2^-S resolution, then round to N+G bits.
  function automatic logic [AW-1:0] c_const(input int k);
    logic [63:0] c;
    logic [63:0] rnd;
    c = 64'd2 << S;
    for (int j = 0; j < k; j++) c = isqrt(c << S);
    rnd = (c + (64'd1 << (S - N - G - 1))) >> (S - N - G);
    return rnd[AW-1:0];
  endfunction

  logic [AW-1:0] c_tab [2**KW];

  generate
    for (genvar gi = 0; gi < 2**KW; gi++) begin : g_ctab
      if (gi >= 1 && gi <= N) begin : g_c
        localparam logic [AW-1:0] CK = c_const(gi);
        assign c_tab[gi] = CK;
      end else begin : g_z
        assign c_tab[gi] = '0;
      end
    end
  endgenerate

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic signed [M:0]   int_q, int_d;
  logic [N-1:0]        frac_q, frac_d;
  logic [M+N:0]        res_q, res_d;
  logic                valid_q, valid_d;
`ifdef EXP2_SAT_FLAG_EN
  logic [1:0]          flag_q, flag_d;
`endif

  logic [2*AW-1:0]     prod;
  logic [M:0]          neg_i;
  logic [SW-1:0]       shifted;
  logic [M+N-1:0]      mag;
  logic                sat;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    int_d   = int_q;
    frac_d  = frac_q;
    res_d   = res_q;
    valid_d = valid_q;
`ifdef EXP2_SAT_FLAG_EN
    flag_d  = flag_q;
`endif
    prod  = acc_q * c_tab[k_q];
    neg_i = -int_q;
    sat   = (int_q >= M_S);
    if (int_q[M]) shifted = SW'(acc_q) >> neg_i;
    else          shifted = SW'(acc_q) << int_q[M-1:0];
    mag = (M + N)'(shifted >> G);

    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          int_d   = number[M+N:N];
          frac_d  = number[N-1:0];
          acc_d   = {2'b01, {(N + G){1'b0}}};
          k_d     = KW'(1);
          state_d = ITER;
        end
      end
      ITER: begin
        // frac is consumed MSB first, so frac_q[N-1] is always f[N-k].
        if (frac_q[N-1]) acc_d = AW'(prod >> (N + G));
        frac_d = frac_q << 1;
        if (k_q == KW'(N)) state_d = SHIFT;
        else               k_d = k_q + KW'(1);
      end
      SHIFT: begin
        res_d   = sat ? SAT_VAL : {1'b0, mag};
        valid_d = 1'b1;
`ifdef EXP2_SAT_FLAG_EN
        flag_d  = {~sat & int_q[M] & (mag == '0), sat};
`endif
        state_d = DONE;
      end
      DONE: begin
        if (oReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      int_q   <= '0;
      frac_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
`ifdef EXP2_SAT_FLAG_EN
      flag_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      res_q   <= res_d;
      valid_q <= valid_d;
`ifdef EXP2_SAT_FLAG_EN
      flag_q  <= flag_d;
`endif
    end
  end

  assign iReady    = (state_q == IDLE);
  assign oValid    = valid_q;
  assign expNumber = res_q;
`ifdef EXP2_SAT_FLAG_EN
  assign oFlag     = flag_q;
`endif

endmodule

// File: tb/tb_exp2_fx.sv
// Directed and randomized bench for exp2_fx against a real-arithmetic model of 2^x.
// Flag checks are compiled in when EXP2_SAT_FLAG_EN is defined.
module tb_exp2_fx;
  localparam int M = 4;
  localparam int N = 10;
  localparam int W = M + N + 1;
  localparam longint SATV = 16383;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         iValid = 1'b0;
  logic         oReady = 1'b0;
  logic [W-1:0] number = '0;
  logic         iReady;
  logic         oValid;
  logic [W-1:0] expNumber;
`ifdef EXP2_SAT_FLAG_EN
  logic [1:0]   oFlag;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  exp2_fx #(.M(M), .N(N), .G(4)) dut (
    .clock(clock),
    .reset(reset),
    .iValid(iValid),
    .iReady(iReady),
    .number(number),
    .oValid(oValid),
    .oReady(oReady),
    .expNumber(expNumber)
`ifdef EXP2_SAT_FLAG_EN
    ,
    .oFlag(oFlag)
`endif
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: product of rounded 2^(2^-k) factors for the set fraction bits,
  // scaled by 2^I, guard bits truncated; saturation for I >= M.
  function automatic longint model(input logic [W-1:0] x);
    longint ii;
    longint acc;
    longint v;
    real    ck;
    ii = $signed(x[W-1:N]);
    if (ii >= M) return SATV;
    acc = 64'd1 << 14;
    for (int k = 1; k <= N; k++) begin
      if (x[N-k]) begin
        ck  = $pow(2.0, $pow(2.0, -k)) * 16384.0;
        acc = (acc * longint'($rtoi(ck + 0.5))) >> 14;
      end
    end
    v = (ii >= 0) ? (acc << ii) : (acc >> (-ii));
    return v >> 4;
  endfunction

  function automatic longint ideal(input logic [W-1:0] x);
    real xr;
    xr = real'($signed(x)) / 1024.0;
    return longint'($rtoi($floor($pow(2.0, xr) * 1024.0)));
  endfunction

  task automatic run_op(input logic [W-1:0] x, output longint res, output int lat);
    int guard;
    @(negedge clock);
    iValid = 1'b1;
    number = x;
    guard = 0;
    while (!iReady && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("accept_timeout", longint'(guard < 50), 1);
    @(posedge clock);
    @(negedge clock);
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 50) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    res = expNumber;
  endtask

  task automatic finish_op();
    oReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    oReady = 1'b0;
    check("handshake_ovalid", oValid, 0);
    check("handshake_iready", iReady, 1);
  endtask

  task automatic check_flags(input logic [W-1:0] x, input longint expv);
`ifdef EXP2_SAT_FLAG_EN
    longint fl;
    fl = 0;
    if ($signed(x[W-1:N]) >= M) fl = 1;
    else if (expv == 0 && x[W-1]) fl = 2;
    check("oflag", oFlag, fl);
`else
    if (x === 'x) $display("[TB] unexpected X operand");
`endif
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] dir_x [11];
    longint       dir_e [11];
    logic [W-1:0] x;
    logic [W-1:0] x2;
    logic [4:0]   ip;
    longint       res;
    longint       hold;
    longint       diff;
    int           lat;
    int           t_first;
    int           t_second;
    int           guard;

    dir_x = '{15'h0000, 15'h0400, 15'h7C00, 15'h0200, 15'h0E00, 15'h1000,
              15'h3FFF, 15'h4000, 15'h5800, 15'h0C00, 15'h5400};
    dir_e = '{1024, 2048, 512, 1448, 11585, SATV, SATV, 0, 1, 8192, 0};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_iready", iReady, 1);
    check("reset_ovalid", oValid, 0);
    check("reset_expnumber", expNumber, 0);
`ifdef EXP2_SAT_FLAG_EN
    check("reset_oflag", oFlag, 0);
`endif
    reset = 1'b1;

    // Directed boundary and accuracy cases
    for (int i = 0; i < 11; i++) begin
      run_op(dir_x[i], res, lat);
      $display("[TB] directed x=%h exp2=%0d expected=%0d lat=%0d", dir_x[i], res, dir_e[i], lat);
      check("directed_result", res, dir_e[i]);
      check("directed_latency", lat, 12);
      check_flags(dir_x[i], dir_e[i]);
      finish_op();
    end

    // Randomized operands against the reference model
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 1) begin
        ip = 5'($urandom_range(28, 35));
        x = {ip, 10'($urandom_range(0, 1023))};
      end else begin
        x = 15'($urandom_range(0, 32767));
      end
      run_op(x, res, lat);
      $display("[TB] random x=%h exp2=%0d model=%0d lat=%0d", x, res, model(x), lat);
      check("random_result", res, model(x));
      check("random_latency", lat, 12);
      check_flags(x, model(x));
      if ($signed(x[W-1:N]) <= 0 && $signed(x[W-1:N]) >= -N) begin
        diff = res - ideal(x);
        if (diff < 0) diff = -diff;
        check("random_accuracy", longint'(diff <= 2), 1);
      end
      finish_op();
    end

    // Backpressure: result held while oReady is low, second operand waits
    x  = 15'h0600;
    x2 = 15'h7E00;
    run_op(x, res, lat);
    hold = res;
    check("bp_first", res, model(x));
    iValid = 1'b1;
    number = x2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_stable", expNumber, hold);
      check("bp_ovalid_held", oValid, 1);
      check("bp_iready_low", iReady, 0);
    end
    oReady = 1'b1;
    @(negedge clock);
    oReady = 1'b0;
    check("bp_release_iready", iReady, 1);
    check("bp_release_ovalid", oValid, 0);
    @(posedge clock);
    @(negedge clock);
    iValid = 1'b0;
    check("bp_second_accepted", iReady, 0);
    guard = 0;
    while (!oValid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    $display("[TB] backpressure x=%h exp2=%0d model=%0d", x2, expNumber, model(x2));
    check("bp_second_result", expNumber, model(x2));
    finish_op();

    // Throughput with oReady and iValid held high
    @(negedge clock);
    oReady = 1'b1;
    iValid = 1'b1;
    number = 15'h0A55;
    t_first = -1;
    t_second = -1;
    for (int c = 0; c < 40; c++) begin
      if (iReady) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
      @(negedge clock);
    end
    iValid = 1'b0;
    $display("[TB] throughput accepts at %0d and %0d", t_first, t_second);
    check("throughput_period", t_second - t_first, 13);
    guard = 0;
    while (!iReady && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    oReady = 1'b0;
    check("throughput_drain", longint'(guard < 50), 1);

    // Asynchronous reset while iterating at k=5
    @(negedge clock);
    iValid = 1'b1;
    number = 15'h0E00;
    check("rst_pre_iready", iReady, 1);
    @(posedge clock);
    @(negedge clock);
    iValid = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_ovalid", oValid, 0);
    check("rst_async_iready", iReady, 1);
    check("rst_async_expnumber", expNumber, 0);
    @(negedge clock);
    reset = 1'b1;
    run_op(15'h0E00, res, lat);
    $display("[TB] post-reset x=0e00 exp2=%0d expected=11585 lat=%0d", res, lat);
    check("rst_after_result", res, 11585);
    check("rst_after_latency", lat, 12);
    finish_op();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
